// File: rtl/dc_filter_seq.sv
// dc_filter_seq: sequencer for the DC-blocking filter datapath.
// Divides CLK_24M down to the 3 MHz sample strobe, runs the fast-settle
// feedback-shift schedule (SHIFT_FAST stepping up to SHIFT_SLOW), then tracks
// and can freeze the filter feedback on request.
// Optional feature: define DC_SEQ_SAT_DETECT_EN to re-run the settle schedule
// after SAT_COUNT consecutive saturated filter outputs seen while tracking.
module dc_filter_seq #(
    parameter int DIV            = 8,
    parameter int SHIFT_FAST     = 8,
    parameter int SHIFT_SLOW     = 16,
    parameter int SETTLE_SAMPLES = 64,
    parameter int SAT_COUNT      = 16
) (
    input  logic       CLK_24M,
    input  logic       reset,
    input  logic       start,
    input  logic       freeze,
    input  logic [8:0] o_data_in,
    output logic       enable_3M,
    output logic [4:0] shift_sel,
    output logic       hold_fb,
    output logic       out_valid,
    output logic [1:0] state,
    output logic       sat_restart
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DIV_W-1:0]  div_cnt_r;
    logic              strobe_s;
    logic              enable_r;
    logic [4:0]        shift_r;
    logic [4:0]        shift_nxt_s;
    logic [4:0]        shift_inc_s;
    logic [SMP_W-1:0]  smp_cnt_r;
    logic [SMP_W-1:0]  smp_nxt_s;
    logic              hold_r;
    logic              valid_r;
    logic              sat_go_s;

    // Strobe request: the divider has reached its terminal count.
    assign strobe_s    = (div_cnt_r == DIV_W'(DIV - 1));
    assign shift_inc_s = shift_r + 5'd1;

    // Free-running sample-rate divider, active in every state.
    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (strobe_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Next-state logic for the settle/track schedule; start outranks everything.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        smp_nxt_s   = smp_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    shift_nxt_s = 5'(SHIFT_FAST);
                    smp_nxt_s   = {SMP_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    shift_nxt_s = 5'(SHIFT_FAST);
                    smp_nxt_s   = {SMP_W{1'b0}};
                end else if (enable_r) begin
                    if (smp_cnt_r == SMP_W'(SETTLE_SAMPLES - 1)) begin
                        smp_nxt_s   = {SMP_W{1'b0}};
                        shift_nxt_s = shift_inc_s;
                        if (shift_inc_s == 5'(SHIFT_SLOW)) begin
                            state_nxt_s = ST_TRACK;
                        end else begin
                            state_nxt_s = ST_SETTLE;
                        end
                    end else begin
                        smp_nxt_s = smp_cnt_r + SMP_W'(1);
                    end
                end else begin
                    smp_nxt_s = smp_cnt_r;
                end
            end
            ST_TRACK: begin
                if (start || sat_go_s) begin
                    state_nxt_s = ST_SETTLE;
                    shift_nxt_s = 5'(SHIFT_FAST);
                    smp_nxt_s   = {SMP_W{1'b0}};
                end else if (freeze) begin
                    state_nxt_s = ST_FREEZE;
                end else begin
                    state_nxt_s = ST_TRACK;
                end
            end
            ST_FREEZE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    shift_nxt_s = 5'(SHIFT_FAST);
                    smp_nxt_s   = {SMP_W{1'b0}};
                end else if (!freeze) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_FREEZE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                shift_nxt_s = 5'(SHIFT_SLOW);
                smp_nxt_s   = {SMP_W{1'b0}};
            end
        endcase
    end

    // Schedule state and registered filter controls, all derived from the next state.
    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= 5'(SHIFT_SLOW);
            smp_cnt_r <= {SMP_W{1'b0}};
            enable_r  <= 1'b0;
            hold_r    <= 1'b1;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            smp_cnt_r <= smp_nxt_s;
            enable_r  <= strobe_s && (state_nxt_s != ST_IDLE);
            hold_r    <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_FREEZE);
            valid_r   <= (state_nxt_s == ST_TRACK) || (state_nxt_s == ST_FREEZE);
        end
    end

`ifdef DC_SEQ_SAT_DETECT_EN
    localparam int SAT_W = (SAT_COUNT > 1) ? $clog2(SAT_COUNT) : 1;

    logic [SAT_W-1:0] sat_cnt_r;
    logic [SAT_W-1:0] sat_step_s;
    logic [SAT_W-1:0] sat_nxt_s;
    logic             sat_sample_s;
    logic             sat_fire_s;
    logic             sat_restart_r;

    // Full-scale positive or negative filter output counts as saturated.
    assign sat_sample_s = (o_data_in == 9'h0FF) || (o_data_in == 9'h100);

    // Run-length of saturated samples while tracking; start suppresses the restart.
    always_comb begin
        sat_fire_s = 1'b0;
        sat_step_s = sat_cnt_r;
        if ((state_r != ST_TRACK) || start) begin
            sat_step_s = {SAT_W{1'b0}};
        end else if (enable_r) begin
            if (sat_sample_s) begin
                if (sat_cnt_r == SAT_W'(SAT_COUNT - 1)) begin
                    sat_fire_s = 1'b1;
                    sat_step_s = {SAT_W{1'b0}};
                end else begin
                    sat_step_s = sat_cnt_r + SAT_W'(1);
                end
            end else begin
                sat_step_s = {SAT_W{1'b0}};
            end
        end else begin
            sat_step_s = sat_cnt_r;
        end
        // A freeze request leaves TRACK, which also ends the run.
        sat_nxt_s = freeze ? {SAT_W{1'b0}} : sat_step_s;
    end

    // Saturation counter and the one-cycle restart pulse.
    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            sat_cnt_r     <= {SAT_W{1'b0}};
            sat_restart_r <= 1'b0;
        end else begin
            sat_cnt_r     <= sat_nxt_s;
            sat_restart_r <= sat_fire_s;
        end
    end

    assign sat_go_s    = sat_fire_s;
    assign sat_restart = sat_restart_r;
`else
    // Reduction parity, used only to consume the filter sample in this build.
    function automatic logic parity9(input logic [8:0] d);
        return ^d;
    endfunction

    logic data_unused_s;

    assign data_unused_s = parity9(o_data_in);
    assign sat_go_s      = 1'b0;
    assign sat_restart   = 1'b0;
`endif

    assign enable_3M = enable_r;
    assign shift_sel = shift_r;
    assign hold_fb   = hold_r;
    assign out_valid = valid_r;
    assign state     = state_r;

endmodule

// File: tb/tb_dc_filter_seq.sv
// Self-checking bench for dc_filter_seq: a schedule-level reference model is
// compared against every output on every cycle, and directed sequences pin the
// model with hand-computed expectations. Works with or without
// DC_SEQ_SAT_DETECT_EN defined.
module tb_dc_filter_seq;

    localparam int DIV   = 8;
    localparam int FAST  = 8;
    localparam int SLOW  = 16;
    localparam int SS    = 64;
    localparam int SATC  = 16;
    localparam int SETTLE_STROBES = (SLOW - FAST) * SS;

    logic       CLK_24M;
    logic       reset;
    logic       start;
    logic       freeze;
    logic [8:0] o_data_in;
    logic       enable_3M;
    logic [4:0] shift_sel;
    logic       hold_fb;
    logic       out_valid;
    logic [1:0] state;
    logic       sat_restart;

    int total = 0;
    int bad   = 0;

    // reference model: schedule expressed as strobes completed since start
    int m_state, m_div, m_prog, m_sat, m_shift;
    bit m_en, m_hold, m_valid, m_satr;

    int shift_hist [32];

    dc_filter_seq #(
        .DIV(DIV), .SHIFT_FAST(FAST), .SHIFT_SLOW(SLOW),
        .SETTLE_SAMPLES(SS), .SAT_COUNT(SATC)
    ) dut (
        .CLK_24M(CLK_24M), .reset(reset), .start(start), .freeze(freeze),
        .o_data_in(o_data_in), .enable_3M(enable_3M), .shift_sel(shift_sel),
        .hold_fb(hold_fb), .out_valid(out_valid), .state(state),
        .sat_restart(sat_restart)
    );

    initial begin
        CLK_24M = 1'b0;
        forever #20 CLK_24M = ~CLK_24M;
    end

    task automatic model_step();
        int  ns;
        bit  strobe_now;
        bit  prev_en;
        if (reset) begin
            m_div = 0; m_en = 1'b0; m_state = 0; m_prog = 0; m_shift = SLOW;
            m_sat = 0; m_satr = 1'b0; m_hold = 1'b1; m_valid = 1'b0;
        end else begin
            strobe_now = (m_div == DIV - 1);
            m_div   = (m_div + 1) % DIV;
            prev_en = m_en;
            ns      = m_state;
            m_satr  = 1'b0;
            if (start) begin
                ns = 1; m_prog = 0;
            end else if (m_state == 1) begin
                if (prev_en) m_prog++;
                if (m_prog == SETTLE_STROBES) ns = 2;
            end else if (m_state == 2) begin
`ifdef DC_SEQ_SAT_DETECT_EN
                if (prev_en) begin
                    if (o_data_in == 9'h0FF || o_data_in == 9'h100) m_sat++;
                    else m_sat = 0;
                end
                if (m_sat == SATC) begin
                    m_satr = 1'b1; ns = 1; m_prog = 0;
                end
`endif
                if (!m_satr && freeze) ns = 3;
            end else if (m_state == 3) begin
                if (!freeze) ns = 2;
            end
            if (ns != 2) m_sat = 0;
            m_state = ns;
            m_en    = strobe_now && (ns != 0);
            m_shift = (ns == 1) ? FAST + m_prog / SS : SLOW;
            m_hold  = (ns == 0) || (ns == 3);
            m_valid = (ns == 2) || (ns == 3);
        end
    endtask

    // per-cycle comparison of every output against the model
    initial begin
        logic [10:0] exp_v, act_v;
        forever begin
            @(posedge CLK_24M);
            model_step();
            #1;
            exp_v = {2'(m_state), m_en, 5'(m_shift), m_hold, m_valid, m_satr};
            act_v = {state, enable_3M, shift_sel, hold_fb, out_valid, sat_restart};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_check t=%0t actual={st,en,sh,hold,val,sat}=%h required=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK_24M);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic check_idle_lits(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_enable"}, int'(enable_3M), 0);
        chk({tag, "_shift"}, int'(shift_sel), 16);
        chk({tag, "_hold"}, int'(hold_fb), 1);
        chk({tag, "_valid"}, int'(out_valid), 0);
    endtask

    // counts SETTLE cycles and strobes from the current cycle until TRACK
    task automatic run_settle(output int n_en, output int n_cyc, output int gap_bad, output bit ok);
        int last;
        n_en = 0; n_cyc = 0; gap_bad = 0; ok = 1'b0; last = -1;
        for (int i = 0; i < 32; i++) shift_hist[i] = 0;
        for (int i = 0; i < 6000; i++) begin
            if (state == 2'd2) begin
                ok = 1'b1;
                break;
            end
            if (state == 2'd1) begin
                if (enable_3M) begin
                    n_en++;
                    shift_hist[shift_sel]++;
                    if (last >= 0 && (n_cyc - last) != DIV) gap_bad++;
                    last = n_cyc;
                end
                n_cyc++;
            end
            cyc(1);
        end
    endtask

    task automatic wait_shift(input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (state == 2'd1 && shift_sel == 5'(v)) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic wait_enable(output bit ok, inout bit seen_sat);
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            cyc(1);
            if (sat_restart) seen_sat = 1'b1;
            if (enable_3M) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int n_en, n_cyc, gap_bad, idle_en;
        bit ok, seen;
        reset = 1'b1; start = 1'b0; freeze = 1'b0; o_data_in = 9'h000;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check_idle_lits("reset");
        idle_en = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (enable_3M) idle_en++;
        end
        chk("idle_no_enable", idle_en, 0);
        check_idle_lits("idle100");

        // full settle schedule
        cyc(10);
        pulse_start();
        chk("start_state", int'(state), 1);
        chk("start_shift", int'(shift_sel), 8);
        run_settle(n_en, n_cyc, gap_bad, ok);
        chk("settle_reached_track", int'(ok), 1);
        chk("settle_strobes", n_en, 512);
        chk("settle_window", int'(n_cyc >= 4096 - DIV && n_cyc <= 4096 + DIV), 1);
        chk("strobe_period", gap_bad, 0);
        chk("hist_shift8", shift_hist[8], 64);
        chk("hist_shift12", shift_hist[12], 64);
        chk("hist_shift15", shift_hist[15], 64);
        chk("track_valid", int'(out_valid), 1);
        chk("track_shift", int'(shift_sel), 16);
        chk("track_hold", int'(hold_fb), 0);

        // freeze for 40 cycles
        freeze = 1'b1;
        cyc(1);
        chk("freeze_state", int'(state), 3);
        chk("freeze_hold", int'(hold_fb), 1);
        chk("freeze_valid", int'(out_valid), 1);
        cyc(39);
        freeze = 1'b0;
        cyc(1);
        chk("unfreeze_state", int'(state), 2);
        chk("unfreeze_hold", int'(hold_fb), 0);

        // start together with freeze in TRACK
        freeze = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0; freeze = 1'b0;
        chk("startfrz_state", int'(state), 1);
        chk("startfrz_shift", int'(shift_sel), 8);
        chk("startfrz_valid", int'(out_valid), 0);

        // restart mid-settle at shift 12
        wait_shift(12, ok);
        chk("reach_shift12", int'(ok), 1);
        pulse_start();
        chk("restart12_shift", int'(shift_sel), 8);
        chk("restart12_valid", int'(out_valid), 0);
        run_settle(n_en, n_cyc, gap_bad, ok);
        chk("restart12_track", int'(ok), 1);
        chk("restart12_strobes", n_en, 512);

        // reset at shift 11
        pulse_start();
        wait_shift(11, ok);
        chk("reach_shift11", int'(ok), 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check_idle_lits("midreset");
        cyc(5);
        pulse_start();
        run_settle(n_en, n_cyc, gap_bad, ok);
        chk("postreset_track", int'(ok), 1);
        chk("postreset_strobes", n_en, 512);

        // 16 saturated samples in TRACK
        seen = 1'b0;
        o_data_in = 9'h0FF;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (sat_restart) begin
                seen = 1'b1;
                break;
            end
        end
`ifdef DC_SEQ_SAT_DETECT_EN
        chk("sat_fired", int'(seen), 1);
        chk("sat_state", int'(state), 1);
        chk("sat_shift", int'(shift_sel), 8);
        o_data_in = 9'h000;
        cyc(1);
        chk("sat_pulse_width", int'(sat_restart), 0);
        run_settle(n_en, n_cyc, gap_bad, ok);
        chk("sat_resettle_track", int'(ok), 1);
`else
        chk("nosat_fired", int'(seen), 0);
        chk("nosat_state", int'(state), 2);
        o_data_in = 9'h000;
`endif

        // 15 saturated samples then one in range: no restart
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_enable(ok, seen);
            if (!ok) chk("enable_timeout", 0, 1);
            o_data_in = (i < 15) ? ((i % 2 == 0) ? 9'h0FF : 9'h100) : 9'h010;
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (sat_restart) seen = 1'b1;
        end
        chk("sat15_no_restart", int'(seen), 0);
        chk("sat15_state", int'(state), 2);

        // randomized stimulus, checked cycle by cycle against the model
        for (int i = 0; i < 20000; i++) begin
            cyc(1);
            reset = ($urandom_range(0, 14999) == 0);
            start = ($urandom_range(0, 9999) == 0);
            if ($urandom_range(0, 49) == 0) freeze = ~freeze;
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 2))
                    0: o_data_in = 9'h0FF;
                    1: o_data_in = 9'h100;
                    default: o_data_in = 9'($urandom);
                endcase
            end
        end
        reset = 1'b0; start = 1'b0; freeze = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dc_filter_seq.md
Name: dc_filter_seq

Overview:
- Sequencer for the DC-blocking filter datapath.
- Divides CLK_24M to generate the 3 MHz sample strobe that drives the filter's enable.
- Runs a fast-settle schedule: the feedback shift starts small (fast DC tracking) and steps up to the final shift. It then tracks, and it can freeze the feedback on request.
- Sits between the front-end control logic and the filter; it owns the enable, shift-select and output-valid signals.

Parameters:
- DIV, 8, CLK_24M cycles per sample strobe (>=2).
- SHIFT_FAST, 8, initial feedback shift during settle.
- SHIFT_SLOW, 16, final feedback shift in track (> SHIFT_FAST, <= 31).
- SETTLE_SAMPLES, 64, strobes spent at each intermediate shift value.
- SAT_COUNT, 16, consecutive saturated samples that trigger a re-settle (optional feature only).

Ports:
- CLK_24M  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level/pulse; request (re)start of the settle schedule.
- freeze  in  1  level; hold filter feedback while in TRACK.
- o_data_in  in  9  signed filter output sample (used only by the optional feature).
- enable_3M  out  1  one-cycle sample strobe to the filter.
- shift_sel  out  5  feedback shift amount applied by the filter.
- hold_fb  out  1  1 = filter must not update its feedback register.
- out_valid  out  1  filter output is settled and usable.
- state  out  2  IDLE=0, SETTLE=1, TRACK=2, FREEZE=3.
- sat_restart  out  1  one-cycle pulse when a saturation re-settle fires.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates occur on the CLK_24M rising edge.
- Reset values:
  - div counter 0, enable_3M 0, state IDLE.
  - shift_sel = SHIFT_SLOW, hold_fb 1, out_valid 0, sat_restart 0.
  - step/sample/sat counters 0.
- Divider:
  - Counter runs 0..DIV-1 continuously after reset, in every state.
  - Strobe condition is counter==DIV-1.
  - enable_3M is registered: it is high in the cycle after the counter equals DIV-1, giving period DIV and duty 1 cycle.
  - enable_3M is gated low in IDLE.
- IDLE:
  - hold_fb=1, out_valid=0.
  - start=1 -> SETTLE on the next edge, with shift_sel=SHIFT_FAST and sample counter cleared.
- SETTLE:
  - hold_fb=0, out_valid=0.
  - The sample counter increments on each enable_3M cycle.
  - When the counter reaches SETTLE_SAMPLES-1 on a strobe: counter clears and shift_sel increments.
  - If the new shift_sel == SHIFT_SLOW -> TRACK.
  - Total settle time: (SHIFT_SLOW-SHIFT_FAST)*SETTLE_SAMPLES strobes.
  - freeze is ignored in SETTLE.
- TRACK:
  - hold_fb=0, out_valid=1, shift_sel=SHIFT_SLOW.
  - freeze=1 -> FREEZE next edge.
- FREEZE:
  - hold_fb=1, out_valid stays 1, enable_3M keeps pulsing.
  - freeze=0 -> TRACK next edge.
- start priority: start=1 in SETTLE/TRACK/FREEZE restarts SETTLE from SHIFT_FAST next edge. It overrides freeze and any same-cycle counter step.
- Simultaneous start and reset: reset wins.
- Reset mid-settle: everything returns to reset values; no schedule is resumed.
- shift_sel changes only on a strobe cycle or a start/reset edge, never between a strobe and the filter's register update.
- Counter widths: sized by $clog2 of their maximum value. There is no wrap beyond the terminal value; counters clear, not overflow.

Optional Feature:
- Macro: DC_SEQ_SAT_DETECT_EN.
- Defined:
  - In TRACK only, on each enable_3M cycle, compare o_data_in with +255 (0x0FF) and -256 (0x100).
  - A saturated sample increments the sat counter; a non-saturated sample clears it.
  - When the count reaches SAT_COUNT: sat_restart pulses 1 cycle, the state goes to SETTLE from SHIFT_FAST, and the sat counter clears.
  - The sat counter also clears on leaving TRACK.
  - start has priority over this restart; when both occur in the same cycle, sat_restart stays 0.
- Not defined: o_data_in is ignored, sat_restart is tied 0, and no sat counter logic is generated.

Test Plan:
- Reset held 3 cycles, then released:
  - state=IDLE, enable_3M=0, shift_sel=16, hold_fb=1, out_valid=0.
  - Outputs hold the same values while idle for 100 cycles.
- Default params, start pulse at cycle 10:
  - enable_3M pulses every 8 cycles.
  - shift_sel=8 for 64 strobes, then 9, ... 15.
  - TRACK with out_valid=1 and shift_sel=16 after exactly 512 strobes (4096 cycles, ±DIV phase).
- In TRACK, freeze=1 for 40 cycles:
  - state=FREEZE, hold_fb=1, out_valid=1.
  - After freeze=0: TRACK with hold_fb=0 next edge.
- start pulse mid-SETTLE while shift_sel=12, plus start asserted together with freeze in TRACK:
  - shift_sel returns to 8, sample count restarts, out_valid=0.
- reset asserted at shift_sel=11:
  - Next edge shows all reset values.
  - A new start runs the full 512-strobe schedule.
- With DC_SEQ_SAT_DETECT_EN:
  - o_data_in=0x0FF for 16 strobes in TRACK -> sat_restart one-cycle pulse, state=SETTLE, shift_sel=8.
  - 15 saturated samples then one 0x010 -> no restart.
  - Without the macro, the same stimulus -> state stays TRACK and sat_restart=0.
